zap_register_file_lvt: RTL



---
 rtl/zap_register_file_lvt_if.sv | 30 +++
 rtl/zap_register_file_lvt.sv | 108 ++++++++++
 2 files changed

// File: rtl/zap_register_file_lvt_if.sv
// Bus bundle for zap_register_file_lvt: two write ports, flattened read lanes,
// clear request and ready flag.
interface zap_register_file_lvt_if #(
  parameter int DATA_WDT = 32,
  parameter int ADDR_WDT = 6,
  parameter int RD_PORTS = 4
);
  logic                         i_clear;
  logic                         i_wen_a;
  logic                         i_wen_b;
  logic [ADDR_WDT-1:0]          i_wr_addr_a;
  logic [ADDR_WDT-1:0]          i_wr_addr_b;
  logic [DATA_WDT-1:0]          i_wr_data_a;
  logic [DATA_WDT-1:0]          i_wr_data_b;
  logic [RD_PORTS*ADDR_WDT-1:0] i_rd_addr;
  logic [RD_PORTS*DATA_WDT-1:0] o_rd_data;
  logic                         o_ready;

  modport master (
    output i_clear, i_wen_a, i_wen_b, i_wr_addr_a, i_wr_addr_b,
           i_wr_data_a, i_wr_data_b, i_rd_addr,
    input  o_rd_data, o_ready
  );

  modport slave (
    input  i_clear, i_wen_a, i_wen_b, i_wr_addr_a, i_wr_addr_b,
           i_wr_data_a, i_wr_data_b, i_rd_addr,
    output o_rd_data, o_ready
  );
endinterface

// File: rtl/zap_register_file_lvt.sv
// Two-bank register file with a live value table selecting the current bank per register.
// Optional macro ZAP_REGF_BYPASS_EN forwards same-cycle write data onto matching read lanes.
module zap_register_file_lvt #(
  parameter int DATA_WDT = 32,
  parameter int DEPTH    = 40,
  parameter int ADDR_WDT = 6,
  parameter int RD_PORTS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  zap_register_file_lvt_if.slave bus
);

`ifdef ZAP_REGF_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_WDT-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]    lvt_q, lvt_d;
  logic [DATA_WDT-1:0] bank_a_q [DEPTH];
  logic [DATA_WDT-1:0] bank_b_q [DEPTH];

  logic                ready;
  logic                wr_a, wr_b;
  logic                a_we;
  logic [ADDR_WDT-1:0] a_addr;
  logic [DATA_WDT-1:0] a_wdata;

  assign ready       = (state_q == ST_READY);
  assign wr_a        = ready && bus.i_wen_a && (int'(bus.i_wr_addr_a) < DEPTH);
  assign wr_b        = ready && bus.i_wen_b && (int'(bus.i_wr_addr_b) < DEPTH);
  assign bus.o_ready = ready;

  // Bank A port is shared between the clear walk and write port A.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvt_d   = lvt_q;
    a_we    = 1'b0;
    a_addr  = bus.i_wr_addr_a;
    a_wdata = bus.i_wr_data_a;
    unique case (state_q)
      ST_CLEAR: begin
        a_we         = 1'b1;
        a_addr       = cnt_q;
        a_wdata      = '0;
        lvt_d[cnt_q] = 1'b0;
        cnt_d        = cnt_q + ADDR_WDT'(1);
        if (int'(cnt_q) == DEPTH - 1) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        a_we = wr_a;
        // Port B is applied last so it wins a same-address collision.
        if (wr_a) lvt_d[bus.i_wr_addr_a] = 1'b0;
        if (wr_b) lvt_d[bus.i_wr_addr_b] = 1'b1;
        if (bus.i_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      lvt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvt_q   <= lvt_d;
    end
  end

  // NOTE: banks carry no reset; the clear walk zeroes bank A and the LVT, which is all reads depend on.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && a_we) bank_a_q[a_addr] <= a_wdata;
    if (i_reset_n && wr_b) bank_b_q[bus.i_wr_addr_b] <= bus.i_wr_data_b;
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_WDT-1:0] ra;
    logic [DATA_WDT-1:0] rd;

    assign ra = bus.i_rd_addr[k*ADDR_WDT +: ADDR_WDT];

    always_comb begin
      rd = '0;
      if (ready && (int'(ra) < DEPTH)) rd = lvt_q[ra] ? bank_b_q[ra] : bank_a_q[ra];
      if (BYPASS_EN && wr_a && (ra == bus.i_wr_addr_a)) rd = bus.i_wr_data_a;
      if (BYPASS_EN && wr_b && (ra == bus.i_wr_addr_b)) rd = bus.i_wr_data_b;
    end

    assign bus.o_rd_data[k*DATA_WDT +: DATA_WDT] = rd;
  end

endmodule
